irq_sched: RTL and testbench

Memory-mapped interrupt controller between the MIPS core and its interrupt-generating peripherals (switch bank, timers, UART). Latches one-cycle device IRQ pulses into pending bits, applies a software mask, selects the highest-priority unmasked source, and runs a request / acknowledge / end-of-interrupt handshake with the CPU so that exactly one source is in service at a time. Sits on the peripheral bridge alongside the device register windows.

---
 rtl/irq_sched_if.sv | 11 +
 rtl/irq_sched.sv | 137 +++++++++++++
 tb/tb_irq_sched.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_sched_if.sv
// Peripheral-bridge register bus seen by irq_sched: word address, write strobe,
// write data and combinational read data.
interface irq_sched_if;
  logic [31:0] ADDR;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (output ADDR, WE, WD, input RD);
  modport slave  (input ADDR, WE, WD, output RD);
endinterface

// File: rtl/irq_sched.sv
// Interrupt controller: latches device IRQ pulses, masks and prioritises them,
// and runs a request / acknowledge / end-of-interrupt handshake with the CPU.
module irq_sched #(
  parameter int          N    = 6,
  parameter logic [31:0] BASE = 32'h0000_7f40
) (
  input  logic           clk,
  input  logic           reset,
  irq_sched_if.slave     bus,
  input  logic [N-1:0]   DEV_IRQ,
  input  logic           ACK,
  output logic           IRQ,
  output logic [3:0]     IRQ_ID
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_SERVICE
  } state_t;

  state_t       state, state_nx;
  logic [N-1:0] mask, pend, req, w1c, ackclr;
  logic [15:0]  ack_cnt;
  logic         irq_nx;
  logic [3:0]   id_nx, sel;
  logic         any, ack_take;

  logic [31:0]  off;
  logic         in_win;
  logic [1:0]   word;
  logic         wr_mask, wr_pend, wr_eoi;
  logic [31:0]  rd;
  logic         unused_ok;

  // Window decode relative to BASE, so BASE need not be 16-byte aligned.
  assign off     = bus.ADDR - BASE;
  assign in_win  = (off[31:4] == 28'd0);
  assign word    = off[3:2];
  assign wr_mask = bus.WE && in_win && (word == 2'd0);
  assign wr_pend = bus.WE && in_win && (word == 2'd1);
  assign wr_eoi  = bus.WE && in_win && (word == 2'd3);
  assign unused_ok = &{1'b0, off[1:0], bus.WD};

  assign req      = pend & mask;
  assign any      = |req;
  assign ack_take = (state == S_ASSERT) && ACK;
  assign w1c      = wr_pend ? bus.WD[N-1:0] : '0;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    sel    = 4'd0;
    ackclr = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) sel = 4'(i);
    end
    for (int i = 0; i < N; i++) begin
      ackclr[i] = ack_take && (IRQ_ID == 4'(i));
    end
  end

  always_comb begin
    state_nx = state;
    irq_nx   = IRQ;
    id_nx    = IRQ_ID;
    unique case (state)
      S_IDLE: begin
        if (any) begin
          state_nx = S_ASSERT;
          irq_nx   = 1'b1;
          id_nx    = sel;
        end
      end
      S_ASSERT: begin
        // Acknowledge takes priority over a simultaneous mask-off or clear.
        if (ACK) begin
          state_nx = S_SERVICE;
          irq_nx   = 1'b0;
        end else if (!any) begin
          state_nx = S_IDLE;
          irq_nx   = 1'b0;
        end else begin
          id_nx    = sel;
        end
      end
      S_SERVICE: begin
        if (wr_eoi) state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        irq_nx   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      IRQ     <= 1'b0;
      IRQ_ID  <= 4'd0;
      mask    <= '0;
      pend    <= '0;
      ack_cnt <= 16'd0;
    end else begin
      state  <= state_nx;
      IRQ    <= irq_nx;
      IRQ_ID <= id_nx;
      if (wr_mask) mask <= bus.WD[N-1:0];
      // Device set is OR-ed last so it beats a same-cycle clear.
      pend <= (pend & ~w1c & ~ackclr) | DEV_IRQ;
      if (ack_take) ack_cnt <= ack_cnt + 16'd1;
    end
  end

  always_comb begin
    rd = 32'd0;
    if (in_win) begin
      unique case (word)
        2'd0: rd[N-1:0] = mask;
        2'd1: rd[N-1:0] = pend;
        2'd2: begin
          rd[3:0]   = IRQ_ID;
          rd[8]     = (state == S_SERVICE);
          rd[9]     = IRQ;
          rd[31:16] = ack_cnt;
        end
        default: rd = 32'd0;
      endcase
    end
  end

  assign bus.RD = rd;

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: expectations are queued as stimulus is applied
// and popped against the DUT outputs.
module tb_irq_sched;
  localparam int          N      = 6;
  localparam logic [31:0] BASE   = 32'h0000_7f40;
  localparam logic [31:0] A_MASK = BASE;
  localparam logic [31:0] A_PEND = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_EOI  = BASE + 32'hC;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] dev_irq;
  logic         ack;
  logic         irq;
  logic [3:0]   irq_id;

  irq_sched_if bus ();

  irq_sched #(.N(N), .BASE(BASE)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .DEV_IRQ (dev_irq),
    .ACK     (ack),
    .IRQ     (irq),
    .IRQ_ID  (irq_id)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h but no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] addr, input logic [31:0] msk);
    bus.ADDR = addr;
    bus.WE   = 1'b0;
    #1;
    check(tag, bus.RD & msk);
  endtask

  // Packs {IRQ_ID, IRQ} so one comparison covers both outputs.
  task automatic chk_irq(input string tag);
    check(tag, {27'd0, irq_id, irq});
  endtask

  function automatic logic [31:0] irq_val(input logic [3:0] id, input logic r);
    return {27'd0, id, r};
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.ADDR = addr;
    bus.WE   = 1'b1;
    bus.WD   = data;
    step();
    bus.WE   = 1'b0;
    bus.WD   = 32'd0;
  endtask

  initial begin
    // Reset held with all device lines high.
    reset    = 1'b0;
    dev_irq  = '1;
    ack      = 1'b0;
    bus.ADDR = 32'd0;
    bus.WE   = 1'b0;
    bus.WD   = 32'd0;
    step();
    step();
    reset   = 1'b1;
    dev_irq = '0;
    push(irq_val(4'd0, 1'b0)); chk_irq("rst_irq");
    push(32'd0); chk_reg("rst_mask", A_MASK, '1);
    push(32'd0); chk_reg("rst_pend", A_PEND, '1);
    push(32'd0); chk_reg("rst_stat", A_STAT, '1);

    // Single source, full handshake.
    wr(A_MASK, 32'hFFFF_FF02);
    push(32'h02); chk_reg("mask_rw", A_MASK, '1);
    push(32'd0);  chk_reg("win_above", BASE + 32'h10, '1);
    push(32'd0);  chk_reg("win_below", BASE - 32'h4, '1);
    dev_irq = 6'h02;
    push(32'h02);
    push(irq_val(4'd0, 1'b0));
    step();
    dev_irq = '0;
    chk_reg("t2_pend", A_PEND, '1);
    chk_irq("t2_irq_latency");
    push(irq_val(4'd1, 1'b1));
    step();
    chk_irq("t2_irq");
    step();
    step();
    ack = 1'b1;
    push(irq_val(4'd1, 1'b0));
    push(32'd0);
    push(32'h0001_0101);
    step();
    ack = 1'b0;
    chk_irq("t2_ack_irq");
    chk_reg("t2_ack_pend", A_PEND, '1);
    chk_reg("t2_ack_stat", A_STAT, '1);
    wr(A_EOI, 32'hDEAD_BEEF);
    push(32'h0001_0000); chk_reg("t2_eoi_stat", A_STAT, 32'hFFFF_0300);
    push(32'd0);         chk_reg("eoi_reads0", A_EOI, '1);

    // Preemption before ACK, then the loser re-requests after EOI.
    wr(A_MASK, 32'h3F);
    dev_irq = 6'h10;
    step();
    dev_irq = 6'h01;
    step();
    dev_irq = '0;
    push(irq_val(4'd4, 1'b1)); chk_irq("t3_id4");
    step();
    push(irq_val(4'd0, 1'b1)); chk_irq("t3_preempt_id0");
    ack = 1'b1;
    push(irq_val(4'd0, 1'b0));
    push(32'h10);
    push(32'h0002_0100);
    step();
    ack = 1'b0;
    chk_irq("t3_ack_irq");
    chk_reg("t3_ack_pend", A_PEND, '1);
    chk_reg("t3_ack_stat", A_STAT, '1);
    wr(A_EOI, 32'd0);
    push(32'd0); check("t3_eoi_irq", {31'd0, irq});
    step();
    push(irq_val(4'd4, 1'b1)); chk_irq("t3_reassert_id4");
    ack = 1'b1;
    step();
    ack = 1'b0;
    push(32'h0003_0104); chk_reg("t3_svc4_stat", A_STAT, '1);
    push(32'd0);         chk_reg("t3_svc4_pend", A_PEND, '1);

    // In service: ACK ignored, new pend accumulates, set beats W1C.
    dev_irq = 6'h04;
    ack     = 1'b1;
    push(irq_val(4'd4, 1'b0));
    push(32'h0003_0104);
    push(32'h04);
    step();
    dev_irq = '0;
    ack     = 1'b0;
    chk_irq("t4_no_req");
    chk_reg("t4_cnt_hold", A_STAT, '1);
    chk_reg("t4_pend_acc", A_PEND, '1);
    bus.ADDR = A_PEND;
    bus.WE   = 1'b1;
    bus.WD   = 32'h04;
    dev_irq  = 6'h04;
    step();
    bus.WE   = 1'b0;
    dev_irq  = '0;
    push(32'h04); chk_reg("t4_set_beats_clr", A_PEND, '1);
    wr(A_PEND, 32'hFFFF_FFFF);
    push(32'd0);  chk_reg("t4_w1c", A_PEND, '1);
    wr(A_EOI, 32'd0);
    step();
    push(32'd0);  check("t4_idle_irq", {31'd0, irq});

    // Mask-off while asserted, then re-enable.
    dev_irq = 6'h08;
    step();
    dev_irq = '0;
    step();
    push(irq_val(4'd3, 1'b1)); chk_irq("t5_id3");
    wr(A_MASK, 32'd0);
    step();
    push(32'd0); check("t5_maskoff_irq", {31'd0, irq});
    push(32'd0); chk_reg("t5_maskoff_stat", A_STAT, 32'h0000_0300);
    wr(A_MASK, 32'h08);
    step();
    push(irq_val(4'd3, 1'b1)); chk_irq("t5_remask_id3");

    // ACK wins over a same-cycle mask-off.
    bus.ADDR = A_MASK;
    bus.WE   = 1'b1;
    bus.WD   = 32'd0;
    ack      = 1'b1;
    push(irq_val(4'd3, 1'b0));
    push(32'h0004_0103);
    push(32'd0);
    step();
    bus.WE   = 1'b0;
    ack      = 1'b0;
    chk_irq("t5_ackwin_irq");
    chk_reg("t5_ackwin_stat", A_STAT, '1);
    chk_reg("t5_ackwin_pend", A_PEND, '1);
    wr(A_EOI, 32'd0);
    wr(A_MASK, 32'h3F);

    // ACK counter wrap.
    force dut.ack_cnt = 16'hFFFF;
    #1;
    release dut.ack_cnt;
    push(32'hFFFF_0000); chk_reg("t6_cnt_preload", A_STAT, 32'hFFFF_0000);
    dev_irq = 6'h01;
    step();
    dev_irq = '0;
    step();
    push(irq_val(4'd0, 1'b1)); chk_irq("t6_req");
    ack = 1'b1;
    step();
    ack = 1'b0;
    push(32'h0000_0100); chk_reg("t6_cnt_wrap", A_STAT, '1);
    wr(A_EOI, 32'd0);

    // Reset mid-handshake overrides ACK and device lines.
    dev_irq = 6'h02;
    step();
    dev_irq = '0;
    step();
    push(irq_val(4'd1, 1'b1)); chk_irq("t7_asserted");
    reset   = 1'b0;
    ack     = 1'b1;
    dev_irq = 6'h3F;
    push(irq_val(4'd0, 1'b0));
    push(32'd0);
    push(32'd0);
    push(32'd0);
    step();
    reset   = 1'b1;
    ack     = 1'b0;
    dev_irq = '0;
    chk_irq("t7_rst_irq");
    chk_reg("t7_rst_stat", A_STAT, '1);
    chk_reg("t7_rst_pend", A_PEND, '1);
    chk_reg("t7_rst_mask", A_MASK, '1);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL leftover_expectations: observed %0d queued, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
